ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Fetch stage feeding the IF/ID pipeline buffer. Owns the PC, runs a req/ready handshake
//  with instruction memory (variable latency), and drives the buffer's pc_next/instr inputs
//  and its enable. Handles hazard-unit stalls, inserts NOP bubbles, and takes branch/jump redirects.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  NOP_INSTR  32'h0000_0000  bubble word; equals the IF/ID buffer's reset instr value
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  stall        in   1   hazard unit: hold IF/ID contents and PC
//  redirect     in   1   branch/jump taken; 1-cycle pulse
//  redirect_pc  in   32  redirect target
//  imem_req     out  1   fetch request; held until imem_ready
//  imem_addr    out  32  fetch address; stable while imem_req=1
//  imem_ready   in   1   transfer completes on a rising edge with imem_req=1 and imem_ready=1
//  imem_rdata   in   32  instruction word; valid in the cycle imem_ready=1
//  pc_next_out  out  32  to IF/ID pc_next_in
//  instr_out    out  32  to IF/ID instr_in
//  ifid_enable  out  1   to IF/ID enable; IF/ID captures on the edge where this is 1
// BEHAVIOUR
//  Registers: pc, req_addr, hold_instr, state in {START, FETCH, HOLD, DRAIN}.
//  Outputs are combinational from state/regs/inputs; zero added latency to IF/ID.
//  Reset (reset=0, async):
//    pc=RESET_PC; req_addr=RESET_PC; hold_instr=NOP_INSTR; state=START.
//    imem_req=0; ifid_enable=0; instr_out=NOP_INSTR; pc_next_out=RESET_PC.
//  START: imem_req=0, ifid_enable=0; next state FETCH.
//    If redirect: pc<=redirect_pc.
//  FETCH: imem_req=1, imem_addr=pc. Priority: redirect > completion > wait.
//    redirect & (ready | !req outstanding beyond this cycle): ifid_enable=1, instr_out=NOP;
//      pc<=redirect_pc; stay FETCH. Completed data is discarded.
//    redirect & !ready: ifid_enable=1 writing NOP; req_addr<=pc; pc<=redirect_pc; ->DRAIN.
//    ready & !stall: ifid_enable=1, instr_out=imem_rdata, pc_next_out=pc+4; pc<=pc+4.
//    ready & stall: ifid_enable=0; hold_instr<=imem_rdata; ->HOLD.
//    !ready: ifid_enable=!stall, instr_out=NOP, pc_next_out=pc (bubble).
//  HOLD: imem_req=0.
//    ifid_enable=!stall, instr_out=hold_instr, pc_next_out=pc+4.
//    !stall: pc<=pc+4; ->FETCH.
//    redirect: NOP written (ifid_enable=1); pc<=redirect_pc; ->FETCH. Redirect overrides stall.
//  DRAIN: imem_req=1, imem_addr=req_addr (address never changes mid-request).
//    ifid_enable=!stall, instr_out=NOP, pc_next_out=pc.
//    ready: data discarded; ->FETCH.
//    redirect: pc<=redirect_pc; ->FETCH if ready, else stay DRAIN.
//  Redirect in any state forces ifid_enable=1 with NOP_INSTR, regardless of stall (flush).
//  PC arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. PC bits [1:0] are not checked.
//  Reset asserted mid-operation (any state, including DRAIN): returns immediately to the reset values.
//    Any outstanding memory transfer is abandoned.
// TESTING
//  1 reset=0 for 3 cycles -> imem_req=0, ifid_enable=0, instr_out=0.
//    After release: 1 START cycle, then imem_req=1, imem_addr=0.
//  2 imem_ready=1 continuously, rdata A,B,C -> addrs 0,4,8.
//    IF/ID writes (pc_next,instr) = (4,A),(8,B),(12,C).
//  3 At addr 8, ready=0 for 2 cycles, then 1 with D -> two NOP writes with pc_next=8, then (12,D).
//  4 ready=1 at addr 4 with stall=1 for 3 cycles -> ifid_enable=0 and imem_req=0 during the stall.
//    On release: write (8,E) and fetch addr 8.
//  5 redirect=1, redirect_pc=0x100, during a zero-wait fetch -> NOP written.
//    Next imem_addr=0x100; ready+stall=1 together -> still flush.
//  6 Pending req at 0x20 with ready=0, redirect to 0x80 -> imem_addr stays 0x20 until ready.
//    That data is dropped; next req at 0x80. Reset during DRAIN -> START, pc=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, handshakes with variable-latency instruction memory and
// feeds the IF/ID buffer, inserting NOP bubbles on stalls, waits and redirects.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_next_out,
  output logic [31:0] instr_out,
  output logic        ifid_enable
);

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_addr_nxt   = req_addr;
    hold_instr_nxt = hold_instr;
    imem_req       = 1'b0;
    imem_addr      = pc;
    ifid_enable    = 1'b0;
    instr_out      = NOP_INSTR;
    pc_next_out    = pc;

    case (state)
      START: begin
        state_nxt = FETCH;
        if (redirect) begin
          ifid_enable = 1'b1;
          pc_nxt      = redirect_pc;
        end
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_enable = 1'b1;
          pc_nxt      = redirect_pc;
          // The request in flight must finish at its original address before refetching.
          if (!imem_ready) begin
            req_addr_nxt = pc;
            state_nxt    = DRAIN;
          end
        end else if (imem_ready) begin
          instr_out   = imem_rdata;
          pc_next_out = pc_plus4;
          if (!stall) begin
            ifid_enable = 1'b1;
            pc_nxt      = pc_plus4;
          end else begin
            hold_instr_nxt = imem_rdata;
            state_nxt      = HOLD;
          end
        end else begin
          ifid_enable = !stall;
        end
      end

      HOLD: begin
        instr_out   = hold_instr;
        pc_next_out = pc_plus4;
        if (redirect) begin
          ifid_enable = 1'b1;
          instr_out   = NOP_INSTR;
          pc_next_out = pc;
          pc_nxt      = redirect_pc;
          state_nxt   = FETCH;
        end else if (!stall) begin
          ifid_enable = 1'b1;
          pc_nxt      = pc_plus4;
          state_nxt   = FETCH;
        end
      end

      DRAIN: begin
        imem_req    = 1'b1;
        imem_addr   = req_addr;
        ifid_enable = !stall || redirect;
        if (redirect) pc_nxt = redirect_pc;
        if (imem_ready) state_nxt = FETCH;
      end

      default: state_nxt = START;
    endcase

    // Outputs show reset values while reset is held, independent of the inputs.
    if (!reset) begin
      imem_req    = 1'b0;
      ifid_enable = 1'b0;
      instr_out   = NOP_INSTR;
      pc_next_out = RESET_PC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= START;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit: drives memory responses, stalls and redirects
// cycle by cycle and compares the IF/ID and memory-side outputs to hand-computed values.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_next_out;
  logic [31:0] instr_out;
  logic        ifid_enable;

  int numCompared;
  int numMismatched;

  localparam logic [31:0] A = 32'hA000_0001;
  localparam logic [31:0] B = 32'hB000_0002;
  localparam logic [31:0] C = 32'hC000_0003;
  localparam logic [31:0] D = 32'hD000_0004;
  localparam logic [31:0] E = 32'hE000_0005;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc_next_out (pc_next_out),
    .instr_out   (instr_out),
    .ifid_enable (ifid_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle before checks.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [31:0] pcn,
                            input logic [31:0] ins);
    checkOutput({tag, ".en"},    {31'd0, ifid_enable}, {31'd0, en});
    checkOutput({tag, ".pcn"},   pc_next_out, pcn);
    checkOutput({tag, ".instr"}, instr_out, ins);
  endtask

  task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
    checkOutput({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) checkOutput({tag, ".addr"}, imem_addr, addr);
  endtask

  // Reset for two cycles, release, and step through the single START cycle.
  task automatic doReset(input string tag);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkReq({tag, ".start"}, 1'b0, 32'd0);
    checkOutput({tag, ".start.en"}, {31'd0, ifid_enable}, 32'd0);
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'd0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    #1;
    checkReq("rst", 1'b0, 32'd0);
    checkWrite("rst", 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    checkReq("start", 1'b0, 32'd0);
    checkOutput("start.en", {31'd0, ifid_enable}, 32'd0);

    // Zero-wait stream.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, A);
    checkReq("zw0", 1'b1, 32'd0);
    checkWrite("zw0", 1'b1, 32'd4, A);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, B);
    checkReq("zw1", 1'b1, 32'd4);
    checkWrite("zw1", 1'b1, 32'd8, B);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, C);
    checkReq("zw2", 1'b1, 32'd8);
    checkWrite("zw2", 1'b1, 32'd12, C);

    // Two wait cycles at address 8 produce bubbles.
    doReset("r1");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, A);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, B);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
      checkReq("wait", 1'b1, 32'd8);
      checkWrite("wait", 1'b1, 32'd8, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, D);
    checkReq("waitdone", 1'b1, 32'd8);
    checkWrite("waitdone", 1'b1, 32'd12, D);
    // Stall while waiting blocks the bubble write.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("waitstall", 1'b1, 32'd12);
    checkOutput("waitstall.en", {31'd0, ifid_enable}, 32'd0);

    // Stall on a completed fetch at address 4.
    doReset("r2");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, A);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, E);
    checkReq("stall0", 1'b1, 32'd4);
    checkOutput("stall0.en", {31'd0, ifid_enable}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, JUNK);
      checkReq("stallhold", 1'b0, 32'd0);
      checkOutput("stallhold.en", {31'd0, ifid_enable}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("release", 1'b0, 32'd0);
    checkWrite("release", 1'b1, 32'd8, E);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("refetch", 1'b1, 32'd8);

    // Redirect during a zero-wait fetch flushes with a NOP.
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, JUNK);
    checkOutput("redir.en", {31'd0, ifid_enable}, 32'd1);
    checkOutput("redir.instr", instr_out, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("redir.tgt", 1'b1, 32'h100);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, JUNK);
    checkOutput("redirstall.en", {31'd0, ifid_enable}, 32'd1);
    checkOutput("redirstall.instr", instr_out, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("redirstall.tgt", 1'b1, 32'h200);

    // Redirect with a pending request drains the old address first.
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, JUNK);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("pend", 1'b1, 32'h20);
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, JUNK);
    checkReq("drain0", 1'b1, 32'h20);
    checkWrite("drain0", 1'b1, 32'h20, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("drain1", 1'b1, 32'h20);
    checkWrite("drain1", 1'b1, 32'h80, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, JUNK);
    checkReq("drain2", 1'b1, 32'h20);
    checkWrite("drain2", 1'b1, 32'h80, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("drained", 1'b1, 32'h80);

    // Reset in the middle of a drain.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, JUNK);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("drainR", 1'b1, 32'h80);
    #1 reset = 1'b0;
    #1;
    checkReq("midrst", 1'b0, 32'd0);
    checkWrite("midrst", 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkReq("midrst.start", 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("midrst.fetch", 1'b1, 32'd0);

    // PC wraps from the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, JUNK);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, C);
    checkReq("wrap", 1'b1, 32'hFFFF_FFFC);
    checkWrite("wrap", 1'b1, 32'd0, C);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, JUNK);
    checkReq("wrap.next", 1'b1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
